// File: rtl/multicore_sobel_cpu_0_dct_packer.sv
// Trace-frame packer for the per-core debug trace buffer. It packs 2-bit atoms into a
// 15-atom frame and hands full or flushed frames to the OCI sink through a one-entry slot.
module multicore_sobel_cpu_0_dct_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        atom_valid,
  input  logic [1:0]  atom,
  output logic        atom_ready,
  input  logic        flush,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [29:0] frame_data,
  output logic [3:0]  frame_count,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        overflow,
  input  logic        overflow_clr
);

  localparam int          ATOM_W = 2;
  localparam int          DEPTH  = 15;
  localparam logic [3:0]  FULL   = 4'(DEPTH);

  logic        flush_pending;
  logic        slot_free;
  logic        accept;
  logic        drop;
  logic        transfer;
  logic [3:0]  idx;
  logic [29:0] buffer_next;
  logic [3:0]  count_next;
  logic        pending_next;

  // atom_ready is advisory and must not depend on atom_valid or flush.
  assign slot_free  = !frame_valid || frame_ready;
  assign atom_ready = (dct_count != FULL) || slot_free;
  assign accept     = atom_valid && atom_ready;
  assign drop       = atom_valid && !atom_ready;
  assign transfer   = slot_free &&
                      ((dct_count == FULL) || (flush_pending && (dct_count != 4'd0)));

  // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    buffer_next = transfer ? '0 : dct_buffer;
    idx         = transfer ? 4'd0 : dct_count;
    if (accept) buffer_next[{idx, 1'b0} +: ATOM_W] = atom;
    count_next  = (transfer ? 4'd0 : dct_count) + {3'b000, accept};
    // A pending flush survives while its partial frame waits for the slot;
    // an empty flush with nothing arriving simply evaporates.
    pending_next = flush ||
                   (flush_pending && !transfer && !((dct_count == 4'd0) && !accept));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer    <= '0;
      dct_count     <= '0;
      flush_pending <= 1'b0;
      frame_valid   <= 1'b0;
      frame_data    <= '0;
      frame_count   <= '0;
      overflow      <= 1'b0;
    end else begin
      dct_buffer    <= buffer_next;
      dct_count     <= count_next;
      flush_pending <= pending_next;

      if (transfer) begin
        frame_valid <= 1'b1;
        frame_data  <= dct_buffer;
        frame_count <= dct_count;
      end else if (frame_ready) begin
        frame_valid <= 1'b0;
      end

      // A drop wins over a simultaneous clear so no loss goes unreported.
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multicore_sobel_cpu_0_dct_packer.sv
// Directed bench for the trace-frame packer: a vector table for the basic frames and
// hand-written sequences for back-pressure, overflow and mid-fill reset.
module tb_multicore_sobel_cpu_0_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        atom_valid;
  logic [1:0]  atom;
  logic        atom_ready;
  logic        flush;
  logic        frame_valid;
  logic        frame_ready;
  logic [29:0] frame_data;
  logic [3:0]  frame_count;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
  logic        overflow_clr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicore_sobel_cpu_0_dct_packer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .atom_valid   (atom_valid),
    .atom         (atom),
    .atom_ready   (atom_ready),
    .flush        (flush),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .frame_data   (frame_data),
    .frame_count  (frame_count),
    .dct_buffer   (dct_buffer),
    .dct_count    (dct_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  typedef struct {
    logic        av;
    logic [1:0]  a;
    logic        fl;
    logic        fr;
    logic [3:0]  e_cnt;
    logic [29:0] e_buf;
    logic        e_fv;
    logic [29:0] e_fd;
    logic [3:0]  e_fc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic add(input logic av, input logic [1:0] a, input logic fl, input logic fr,
                     input logic [3:0] e_cnt, input logic [29:0] e_buf, input logic e_fv,
                     input logic [29:0] e_fd, input logic [3:0] e_fc);
    vec_t v;
    v.av = av; v.a = a; v.fl = fl; v.fr = fr;
    v.e_cnt = e_cnt; v.e_buf = e_buf; v.e_fv = e_fv; v.e_fd = e_fd; v.e_fc = e_fc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic av, input logic [1:0] a, input logic fl,
                       input logic fr, input logic clr);
    atom_valid = av; atom = a; flush = fl; frame_ready = fr; overflow_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_buf"},   32'(dct_buffer),  32'h0);
    check({tag, "_cnt"},   32'(dct_count),   32'h0);
    check({tag, "_fv"},    32'(frame_valid), 32'h0);
    check({tag, "_fd"},    32'(frame_data),  32'h0);
    check({tag, "_fc"},    32'(frame_count), 32'h0);
    check({tag, "_ov"},    32'(overflow),    32'h0);
    check({tag, "_ready"}, 32'(atom_ready),  32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [29:0] b;
    logic [29:0] all_10;

    // 15 atoms of 01 with the sink always ready
    b = '0;
    for (int k = 0; k < 15; k++) begin
      b = b | (30'h1 << (2 * k));
      add(1'b1, 2'b01, 1'b0, 1'b1, 4'(k + 1), b, 1'b0, 30'h0, 4'd0);
    end
    add(1'b0, 2'b00, 1'b0, 1'b1, 4'd0, 30'h0, 1'b1, 30'h15555555, 4'd15);
    add(1'b0, 2'b00, 1'b0, 1'b1, 4'd0, 30'h0, 1'b0, 30'h0, 4'd0);
    // atoms 3, 2, 1 then flush
    add(1'b1, 2'b11, 1'b0, 1'b1, 4'd1, 30'h03, 1'b0, 30'h0, 4'd0);
    add(1'b1, 2'b10, 1'b0, 1'b1, 4'd2, 30'h0B, 1'b0, 30'h0, 4'd0);
    add(1'b1, 2'b01, 1'b0, 1'b1, 4'd3, 30'h1B, 1'b0, 30'h0, 4'd0);
    add(1'b0, 2'b00, 1'b1, 1'b1, 4'd3, 30'h1B, 1'b0, 30'h0, 4'd0);
    add(1'b0, 2'b00, 1'b0, 1'b1, 4'd0, 30'h0,  1'b1, 30'h1B, 4'd3);
    add(1'b0, 2'b00, 1'b0, 1'b1, 4'd0, 30'h0,  1'b0, 30'h0, 4'd0);
    // empty flush emits nothing, then flush together with atom 11 at count 0
    add(1'b0, 2'b00, 1'b1, 1'b1, 4'd0, 30'h0, 1'b0, 30'h0, 4'd0);
    add(1'b0, 2'b00, 1'b0, 1'b1, 4'd0, 30'h0, 1'b0, 30'h0, 4'd0);
    add(1'b0, 2'b00, 1'b0, 1'b1, 4'd0, 30'h0, 1'b0, 30'h0, 4'd0);
    add(1'b1, 2'b11, 1'b1, 1'b1, 4'd1, 30'h3, 1'b0, 30'h0, 4'd0);
    add(1'b0, 2'b00, 1'b0, 1'b1, 4'd0, 30'h0, 1'b1, 30'h3, 4'd1);
    add(1'b0, 2'b00, 1'b0, 1'b1, 4'd0, 30'h0, 1'b0, 30'h0, 4'd0);

    reset_n = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    #12;
    check_reset_values("por");
    reset_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].av, vecs[i].a, vecs[i].fl, vecs[i].fr, 1'b0);
      tick();
      check($sformatf("vec%0d_cnt", i), 32'(dct_count),   32'(vecs[i].e_cnt));
      check($sformatf("vec%0d_buf", i), 32'(dct_buffer),  32'(vecs[i].e_buf));
      check($sformatf("vec%0d_fv", i),  32'(frame_valid), 32'(vecs[i].e_fv));
      if (vecs[i].e_fv) begin
        check($sformatf("vec%0d_fd", i), 32'(frame_data),  32'(vecs[i].e_fd));
        check($sformatf("vec%0d_fc", i), 32'(frame_count), 32'(vecs[i].e_fc));
      end
    end
    check("tbl_ov", 32'(overflow), 32'h0);

    // Back-pressure: 31 atoms of 10 with the sink stalled
    all_10 = 30'h2AAAAAAA;
    for (int k = 1; k <= 15; k++) begin
      drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("bp_cnt15", 32'(dct_count), 32'd15);
    check("bp_fv_pre", 32'(frame_valid), 32'h0);
    tick();  // atom 16: transfer and accept coincide
    check("bp_fv", 32'(frame_valid), 32'h1);
    check("bp_fd", 32'(frame_data), 32'(all_10));
    check("bp_fc", 32'(frame_count), 32'd15);
    check("bp_cnt1", 32'(dct_count), 32'd1);
    for (int k = 17; k <= 30; k++) begin
      tick();
      check($sformatf("bp_hold_fd%0d", k), 32'(frame_data), 32'(all_10));
    end
    check("bp_hold_fv", 32'(frame_valid), 32'h1);
    check("bp_hold_fc", 32'(frame_count), 32'd15);
    check("bp_cnt_full", 32'(dct_count), 32'd15);
    check("bp_ready0", 32'(atom_ready), 32'h0);
    tick();  // atom 31 dropped
    check("bp_ov", 32'(overflow), 32'h1);
    check("bp_cnt_drop", 32'(dct_count), 32'd15);
    check("bp_buf_drop", 32'(dct_buffer), 32'(all_10));
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    tick();
    check("bp2_fv", 32'(frame_valid), 32'h1);
    check("bp2_fd", 32'(frame_data), 32'(all_10));
    check("bp2_fc", 32'(frame_count), 32'd15);
    check("bp2_cnt", 32'(dct_count), 32'd0);
    tick();
    check("bp2_drain", 32'(frame_valid), 32'h0);

    // Overflow: clear coinciding with a new drop keeps it set
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++) tick();
    check("ov_cnt", 32'(dct_count), 32'd15);
    check("ov_ready0", 32'(atom_ready), 32'h0);
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    tick();
    check("ov_clr_drop", 32'(overflow), 32'h1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    tick();
    check("ov_clr", 32'(overflow), 32'h0);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    check("ov_drained_cnt", 32'(dct_count), 32'd0);
    tick();
    check("ov_drained_fv", 32'(frame_valid), 32'h0);

    // Reset mid-fill with a held frame
    drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 22; k++) tick();
    check("rst_pre_cnt", 32'(dct_count), 32'd7);
    check("rst_pre_fv", 32'(frame_valid), 32'h1);
    drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check_reset_values("mid");
    #2;
    reset_n = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    tick();
    check("post_fv_idle", 32'(frame_valid), 32'h0);
    drive(1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 15; k++) begin
      tick();
      check($sformatf("post_fill_fv%0d", k), 32'(frame_valid), 32'h0);
    end
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    tick();
    check("post_fv", 32'(frame_valid), 32'h1);
    check("post_fd", 32'(frame_data), 32'h15555555);
    check("post_fc", 32'(frame_count), 32'd15);
    check("post_ov", 32'(overflow), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
